ffbank: RTL and testbench

Parametrised bank of WIDTH independent edge-triggered flip-flops sharing one clock and one run-time mode select (SR, JK, D or T). It is the general-purpose storage element for the tutorial designs that previously instantiated single-bit SR flip-flops. The SR forbidden input is defined behaviour here: the bit holds its value and an error is flagged. Outputs are never driven to high-impedance.

---
 rtl/ffbank.sv | 65 ++++++
 tb/tb_ffbank.sv | 88 ++++++++
 2 files changed

// File: rtl/ffbank.sv
// ffbank: WIDTH-bit bank of edge-triggered flip-flops with one run-time mode (SR, JK, D or T)
//   clk, rst (sync, active-high), en (clock enable), mode (00 SR, 01 JK, 10 D, 11 T),
//   a (S/J/D/T), b (R/K), err_clr -> q, qbar, err (per-bit SR illegal), err_sticky, err_count.
//   The err_count register is present only when FFBANK_ERR_CNT_EN is defined; otherwise it reads 0.
module ffbank #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar,
  output logic [WIDTH-1:0]     err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {SR = 2'b00, JK = 2'b01, D = 2'b10, T = 2'b11} mode_t;
  mode_t m;
  logic [WIDTH-1:0] nxt, ill;
  assign m = mode_t'(mode);
  // SR: set on 10, reset on 01, hold on 00 and on the illegal 11
  always_comb begin
    nxt = q;
    ill = '0;
    if (en) begin
      nxt = (m == SR) ? ((a & ~b) | (q & ~(a ^ b))) :
            (m == JK) ? ((a & ~q) | (~b & q)) :
            (m == D)  ? a : (q ^ a);
      ill = (m == SR) ? (a & b) : '0;
    end
  end
  // qbar is its own register loaded with ~nxt so it never equals q
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
      qbar <= ~RST_VAL;
      err <= '0;
      err_sticky <= 1'b0;
    end else begin
      q <= nxt;
      qbar <= ~nxt;
      err <= ill;
      err_sticky <= (|ill) ? 1'b1 : (err_clr ? 1'b0 : err_sticky);
    end
  end
`ifdef FFBANK_ERR_CNT_EN
  // a new illegal event beats a simultaneous clear and restarts the count at 1
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (|ill)
      err_count <= err_clr ? ERR_CNT_W'(1) : ((&err_count) ? err_count : err_count + 1'b1);
    else if (err_clr)
      err_count <= '0;
  end
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_ffbank.sv
module tb_ffbank;
  logic clk = 0, rst = 0, en = 0, err_clr = 0;
  logic [1:0] mode = 0;
  logic [7:0] a = 0, b = 0, q, qbar, err;
  logic err_sticky;
  logic [1:0] err_count;
  int checks = 0, failures = 0;

  ffbank #(.WIDTH(8), .RST_VAL(8'h0F), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q), .qbar(qbar), .err(err), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ce(input logic [1:0] n);
`ifdef FFBANK_ERR_CNT_EN
    return n;
`else
    return 2'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] eq, input logic [7:0] eerr,
                      input logic es, input logic [1:0] ec);
    @(posedge clk);
    #1;
    chk({tag, ".q"}, q, eq);
    chk({tag, ".qbar"}, qbar, ~eq);
    chk({tag, ".err"}, err, eerr);
    chk({tag, ".sticky"}, {7'd0, err_sticky}, {7'd0, es});
    chk({tag, ".count"}, {6'd0, err_count}, {6'd0, ec});
  endtask

  initial begin
    rst = 1; a = 8'hA5; b = 8'h5A; en = 1; mode = 2'b10;
    step("reset", 8'h0F, 8'h00, 0, 0);
    rst = 0; mode = 2'b00; a = 8'hF0; b = 8'h00;
    step("sr_set", 8'hFF, 8'h00, 0, 0);
    a = 8'h00; b = 8'h0F;
    step("sr_rst", 8'hF0, 8'h00, 0, 0);
    mode = 2'b10; a = 8'h01; b = 8'h00;
    step("d_01", 8'h01, 8'h00, 0, 0);
    mode = 2'b00; a = 8'h01; b = 8'h01;
    step("sr_ill1", 8'h01, 8'h01, 1, ce(1));
    step("sr_ill2", 8'h01, 8'h01, 1, ce(2));
    step("sr_ill3", 8'h01, 8'h01, 1, ce(3));
    a = 8'h00; b = 8'h00;
    step("sr_hold", 8'h01, 8'h00, 1, ce(3));
    mode = 2'b10;
    step("d_00", 8'h00, 8'h00, 1, ce(3));
    mode = 2'b01; a = 8'hFF; b = 8'hFF;
    step("jk_tog1", 8'hFF, 8'h00, 1, ce(3));
    step("jk_tog2", 8'h00, 8'h00, 1, ce(3));
    mode = 2'b11; a = 8'hAA; b = 8'hFF;
    step("t_aa", 8'hAA, 8'h00, 1, ce(3));
    mode = 2'b10; a = 8'h5C; b = 8'hFF;
    step("d_5c", 8'h5C, 8'h00, 1, ce(3));
    en = 0; a = 8'hFF;
    step("en0_d", 8'h5C, 8'h00, 1, ce(3));
    mode = 2'b00; a = 8'hFF; b = 8'hFF;
    step("en0_sr", 8'h5C, 8'h00, 1, ce(3));
    en = 1; mode = 2'b10; a = 8'h33; rst = 1;
    step("rst_mid", 8'h0F, 8'h00, 0, 0);
    rst = 0; mode = 2'b00; a = 8'h03; b = 8'h03;
    step("sat1", 8'h0F, 8'h03, 1, ce(1));
    step("sat2", 8'h0F, 8'h03, 1, ce(2));
    step("sat3", 8'h0F, 8'h03, 1, ce(3));
    step("sat4", 8'h0F, 8'h03, 1, ce(3));
    step("sat5", 8'h0F, 8'h03, 1, ce(3));
    a = 8'h00; b = 8'h00; err_clr = 1;
    step("clr", 8'h0F, 8'h00, 0, 0);
    a = 8'h80; b = 8'h80;
    step("clr_ill", 8'h0F, 8'h80, 1, ce(1));
    err_clr = 0; a = 8'h00; b = 8'h00;
    step("after", 8'h0F, 8'h00, 1, ce(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
